imm_decode_stage: RTL and testbench
===================================

// Module: imm_decode_stage
// PURPOSE
//  Registered decode-stage immediate generator with a valid/ready handshake.
//  - Decodes the immediate type from the opcode/funct3 itself; no external immOp.
//  - Emits the XLEN-wide sign-extended immediate and the PC-relative target (pc+imm).
//  - Sits between IF/ID and the execute stage; a 2-entry skid buffer breaks the ready path.
// PARAMETERS
//  XLEN  32  datapath width; only 32 or 64 legal, any other value is an elaboration $error
//  SKID  1   1: 2-entry skid buffer, registered in_ready; 0: single register, in_ready=!out_valid|out_ready
// PORTS
//  clk          in   1     clock; all state updates on posedge
//  rst          in   1     synchronous, active-high reset
//  flush        in   1     drop all held entries (branch mispredict/trap)
//  in_valid     in   1     upstream entry valid
//  in_ready     out  1     stage can accept this cycle
//  in_inst      in   32    raw instruction
//  in_pc        in   XLEN  instruction PC
//  out_valid    out  1     decoded entry valid
//  out_ready    in   1     downstream accepts
//  out_inst     out  32    instruction, passed through
//  out_pc       out  XLEN  PC, passed through
//  out_imm      out  XLEN  decoded immediate
//  out_immType  out  3     0=I 1=S 2=B 3=U 4=J 5=Z(csr zimm) 6=SH(shamt) 7=NONE
//  out_target   out  XLEN  out_pc+out_imm, modulo 2^XLEN
//  out_illegal  out  1     inst[1:0]!=2'b11 or unmapped opcode
// BEHAVIOUR
//  Reset: out_valid=0, all data outputs=0, FSM=EMPTY; in_ready=0 while rst high, 1 the cycle after.
//  Transfers: in fires on in_valid&in_ready; out fires on out_valid&out_ready.
//  Latency: 1 cycle from in-fire to out_valid; FIFO order preserved, no loss, no duplication.
//  Stability: out_* held constant while out_valid&!out_ready.
//  Decode table (opcode -> type):
//   - 0000011, 1100111 -> I
//   - 0010011 -> SH if funct3 is 001/101, else I
//   - 0011011 (XLEN=64 only) -> SH if funct3 is 001/101, else I
//   - 0100011 -> S; 1100011 -> B; 0110111, 0010111 -> U; 1101111 -> J
//   - 1110011 with funct3[2]=1 -> Z; other 1110011 -> NONE, not illegal
//   - anything else -> NONE, out_illegal=1
//  Immediates (sign bit = inst[31]):
//   - I: inst[31:20]; S: {inst[31:25],inst[11:7]}
//   - B: {inst[31],inst[7],inst[30:25],inst[11:8],0}
//   - J: {inst[31],inst[19:12],inst[20],inst[30:21],0}
//   - U: {inst[31:12],12'b0}, sign-extended to XLEN when XLEN=64
//   - Z: zero-extended inst[19:15]
//   - SH: zero-extended inst[24:20] for XLEN=32 or opcode 0011011, else inst[25:20]
//   - NONE: imm=0, so target=pc
//  SKID=1 FSM (state = number of held entries):
//   - EMPTY: in-fire -> ONE.
//   - ONE: in-fire & !out-fire -> TWO (new entry to skid reg); out-fire & !in-fire -> EMPTY; both -> ONE.
//   - TWO: in_ready=0; out-fire -> ONE, skid reg moves to output reg.
//  flush: priority over every other event; next cycle state=EMPTY, out_valid=0.
//   - An in-fire in the flush cycle is discarded.
//   - in_ready is 1 the cycle after flush.
//  rst mid-operation: same effect as flush, plus all data registers cleared.
//  Simultaneous in-fire and out-fire in EMPTY is impossible: out_valid=0 in EMPTY.
// TESTING
//  1 XLEN=32, in_inst=0xFE000EE3 (beq x0,x0,-4), pc=0x100 -> imm=0xFFFFFFFC, type=2, target=0x000000FC, 1 cycle later.
//  2 0x0080006F (jal x0,8), pc=0x200 -> imm=0x8, type=4, target=0x208.
//  3 XLEN=32, 0x41F0D093 (srai x1,x1,31) -> type=6, imm=0x1F (not 0x41F).
//    Then csrrwi with rs1 field=31 -> type=5, imm=0x1F.
//  4 XLEN=64, 0x800000B7 (lui) -> imm=0xFFFFFFFF80000000.
//    Then 0x00000000 -> out_illegal=1, imm=0, type=7.
//  5 SKID=1, out_ready=0, send A,B,C back-to-back -> A,B accepted, in_ready=0 on the cycle C is presented.
//    Then out_ready=1 -> A,B,C emerge in order, outputs stable while stalled.
//  6 FSM=TWO, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1.
//    Neither held entry nor the new one ever appears; repeat with rst mid-stream -> all outputs 0.

Source files
------------

// File: rtl/imm_decode_stage.sv
// rtl/imm_decode_stage.sv - registered RISC-V immediate decode stage with skid buffer
module imm_decode_stage #(
  parameter int XLEN = 32,
  parameter int SKID = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_immType,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal
);

  localparam logic [2:0] T_I    = 3'd0;
  localparam logic [2:0] T_S    = 3'd1;
  localparam logic [2:0] T_B    = 3'd2;
  localparam logic [2:0] T_U    = 3'd3;
  localparam logic [2:0] T_J    = 3'd4;
  localparam logic [2:0] T_Z    = 3'd5;
  localparam logic [2:0] T_SH   = 3'd6;
  localparam logic [2:0] T_NONE = 3'd7;

  // One decoded entry: {inst, pc, imm, type, target, illegal}
  localparam int DW = 32 + 3 * XLEN + 4;

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_decode_stage: XLEN must be 32 or 64");
  end

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [2:0]      dec_type;
  logic            dec_ill;
  logic [XLEN-1:0] dec_imm;
  logic [XLEN-1:0] dec_target;
  logic [DW-1:0]   dec_word;
  logic [DW-1:0]   head_q;
  logic            vld_q;
  logic            in_fire;
  logic            out_fire;

  assign opc = in_inst[6:0];
  assign f3  = in_inst[14:12];

  // Classify the instruction and build its immediate; inst[1:0]!=11 never matches a mapped opcode
  always_comb begin
    dec_type = T_NONE;
    dec_ill  = 1'b0;
    case (opc)
      7'b0000011, 7'b1100111: dec_type = T_I;
      7'b0010011: dec_type = (f3 == 3'b001 || f3 == 3'b101) ? T_SH : T_I;
      7'b0011011: begin
        if (XLEN == 64) dec_type = (f3 == 3'b001 || f3 == 3'b101) ? T_SH : T_I;
        else            dec_ill  = 1'b1;
      end
      7'b0100011: dec_type = T_S;
      7'b1100011: dec_type = T_B;
      7'b0110111, 7'b0010111: dec_type = T_U;
      7'b1101111: dec_type = T_J;
      7'b1110011: dec_type = f3[2] ? T_Z : T_NONE;
      default: dec_ill = 1'b1;
    endcase

    dec_imm = '0;
    case (dec_type)
      T_I: dec_imm = XLEN'($signed(in_inst[31:20]));
      T_S: dec_imm = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
      T_B: dec_imm = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
      T_U: dec_imm = XLEN'($signed({in_inst[31:12], 12'b0}));
      T_J: dec_imm = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));
      T_Z: dec_imm = XLEN'(in_inst[19:15]);
      T_SH: begin
        // Word-sized shifts only have a 5-bit shamt even on a 64-bit core
        if (XLEN == 32 || opc == 7'b0011011) dec_imm = XLEN'(in_inst[24:20]);
        else                                 dec_imm = XLEN'(in_inst[25:20]);
      end
      default: dec_imm = '0;
    endcase
  end

  assign dec_target = in_pc + dec_imm;
  assign dec_word   = {in_inst, in_pc, dec_imm, dec_type, dec_target, dec_ill};

  assign in_fire  = in_valid & in_ready;
  assign out_fire = vld_q & out_ready;

  assign out_valid = vld_q;
  assign {out_inst, out_pc, out_imm, out_immType, out_target, out_illegal} = head_q;

  if (SKID != 0) begin : g_skid
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    state_t        state_q;
    logic [DW-1:0] skid_q;
    logic          rdy_q;

    // ready is registered; rst gates it so nothing is accepted while reset is held
    assign in_ready = rdy_q & ~rst;

    // Occupancy FSM: head_q is the output register, skid_q holds the second entry
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= EMPTY;
        vld_q   <= 1'b0;
        rdy_q   <= 1'b1;
        head_q  <= '0;
        skid_q  <= '0;
      end else if (flush) begin
        state_q <= EMPTY;
        vld_q   <= 1'b0;
        rdy_q   <= 1'b1;
      end else begin
        case (state_q)
          EMPTY: begin
            if (in_fire) begin
              head_q  <= dec_word;
              vld_q   <= 1'b1;
              state_q <= ONE;
            end
          end
          ONE: begin
            if (in_fire && !out_fire) begin
              skid_q  <= dec_word;
              state_q <= TWO;
              rdy_q   <= 1'b0;
            end else if (in_fire && out_fire) begin
              head_q  <= dec_word;
            end else if (out_fire) begin
              vld_q   <= 1'b0;
              state_q <= EMPTY;
            end
          end
          TWO: begin
            if (out_fire) begin
              head_q  <= skid_q;
              state_q <= ONE;
              rdy_q   <= 1'b1;
            end
          end
          default: begin
            state_q <= EMPTY;
            vld_q   <= 1'b0;
            rdy_q   <= 1'b1;
          end
        endcase
      end
    end
  end else begin : g_single
    assign in_ready = (~vld_q | out_ready) & ~rst;

    // Single pipeline register: load on accept, drain on consume
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q  <= 1'b0;
        head_q <= '0;
      end else if (flush) begin
        vld_q  <= 1'b0;
      end else if (in_fire) begin
        head_q <= dec_word;
        vld_q  <= 1'b1;
      end else if (out_fire) begin
        vld_q  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imm_decode_stage.sv
// tb/tb_imm_decode_stage.sv - directed self-checking bench for imm_decode_stage
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] inst, pc;
  logic [63:0] pc64;

  logic        d_in_ready, d_out_valid, d_out_ill;
  logic [31:0] d_out_inst, d_out_pc, d_out_imm, d_out_target;
  logic [2:0]  d_out_type;

  logic        w_in_ready, w_out_valid, w_out_ill;
  logic [31:0] w_out_inst;
  logic [63:0] w_out_pc, w_out_imm, w_out_target;
  logic [2:0]  w_out_type;

  logic        z_in_ready, z_out_valid, z_out_ill;
  logic [31:0] z_out_inst, z_out_pc, z_out_imm, z_out_target;
  logic [2:0]  z_out_type;

  int tests = 0;
  int fails = 0;

  assign pc64 = {32'h0, pc};

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(32), .SKID(1)) d (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(d_in_ready),
    .in_inst(inst), .in_pc(pc), .out_valid(d_out_valid), .out_ready(out_ready),
    .out_inst(d_out_inst), .out_pc(d_out_pc), .out_imm(d_out_imm), .out_immType(d_out_type),
    .out_target(d_out_target), .out_illegal(d_out_ill));

  imm_decode_stage #(.XLEN(64), .SKID(1)) w (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_inst(inst), .in_pc(pc64), .out_valid(w_out_valid), .out_ready(out_ready),
    .out_inst(w_out_inst), .out_pc(w_out_pc), .out_imm(w_out_imm), .out_immType(w_out_type),
    .out_target(w_out_target), .out_illegal(w_out_ill));

  imm_decode_stage #(.XLEN(32), .SKID(0)) z (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(z_in_ready),
    .in_inst(inst), .in_pc(pc), .out_valid(z_out_valid), .out_ready(out_ready),
    .out_inst(z_out_inst), .out_pc(z_out_pc), .out_imm(z_out_imm), .out_immType(z_out_type),
    .out_target(z_out_target), .out_illegal(z_out_ill));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic [31:0] i, input logic [31:0] p);
    inst = i;
    pc = p;
    in_valid = 1'b1;
  endtask

  // Send one instruction with out_ready=1 and check the 32-bit skid instance one cycle later
  task automatic dec32(input string tag, input logic [31:0] i, input logic [31:0] p,
                       input logic [31:0] imm, input logic [2:0] typ,
                       input logic [31:0] tgt, input logic ill);
    present(i, p);
    step();
    in_valid = 1'b0;
    chk({tag, ".valid"}, d_out_valid, 1'b1);
    chk({tag, ".inst"}, d_out_inst, i);
    chk({tag, ".imm"}, d_out_imm, imm);
    chk({tag, ".type"}, d_out_type, typ);
    chk({tag, ".target"}, d_out_target, tgt);
    chk({tag, ".illegal"}, d_out_ill, ill);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    inst = 32'h0; pc = 32'h0;
    step();
    step();
    chk("rst.out_valid", d_out_valid, 1'b0);
    chk("rst.in_ready", d_in_ready, 1'b0);
    chk("rst.imm", d_out_imm, 32'h0);
    chk("rst.target", d_out_target, 32'h0);
    chk("rst.w_imm", w_out_imm, 64'h0);
    rst = 1'b0;
    step();
    chk("post_rst.in_ready", d_in_ready, 1'b1);
    chk("post_rst.out_valid", d_out_valid, 1'b0);

    // decode table, XLEN=32
    dec32("beq",   32'hFE000EE3, 32'h100, 32'hFFFFFFFC, 3'd2, 32'h000000FC, 1'b0);
    chk("beq.single_imm", z_out_imm, 32'hFFFFFFFC);
    dec32("jal",   32'h0080006F, 32'h200, 32'h00000008, 3'd4, 32'h00000208, 1'b0);
    dec32("srai",  32'h41F0D093, 32'h0,   32'h0000001F, 3'd6, 32'h0000001F, 1'b0);
    dec32("csrwi", 32'h340FD0F3, 32'h300, 32'h0000001F, 3'd5, 32'h0000031F, 1'b0);
    dec32("addi",  32'hFFF00093, 32'h10,  32'hFFFFFFFF, 3'd0, 32'h0000000F, 1'b0);
    dec32("sw",    32'hFE112E23, 32'h20,  32'hFFFFFFFC, 3'd1, 32'h0000001C, 1'b0);
    dec32("lui32", 32'h800000B7, 32'h0,   32'h80000000, 3'd3, 32'h80000000, 1'b0);
    dec32("ecall", 32'h00000073, 32'h40,  32'h00000000, 3'd7, 32'h00000040, 1'b0);

    // XLEN=64 sign extension, word shift, and illegal encodings
    dec32("lui64", 32'h800000B7, 32'h0,   32'h80000000, 3'd3, 32'h80000000, 1'b0);
    chk("lui64.w_imm", w_out_imm, 64'hFFFFFFFF80000000);
    chk("lui64.w_type", w_out_type, 3'd3);
    dec32("zero",  32'h00000000, 32'h50,  32'h00000000, 3'd7, 32'h00000050, 1'b1);
    chk("zero.w_illegal", w_out_ill, 1'b1);
    chk("zero.w_imm", w_out_imm, 64'h0);
    chk("zero.w_type", w_out_type, 3'd7);
    dec32("slliw32", 32'h01F0909B, 32'h60, 32'h00000000, 3'd7, 32'h00000060, 1'b1);
    chk("slliw64.type", w_out_type, 3'd6);
    chk("slliw64.imm", w_out_imm, 64'h1F);
    chk("slliw64.illegal", w_out_ill, 1'b0);
    step();
    chk("drain.out_valid", d_out_valid, 1'b0);

    // skid fill: A, B accepted with out_ready=0, C refused
    out_ready = 1'b0;
    present(32'h00100093, 32'h1000);
    chk("fillA.in_ready", d_in_ready, 1'b1);
    step();
    present(32'h00200113, 32'h1004);
    chk("fillB.in_ready", d_in_ready, 1'b1);
    chk("single.fillB.in_ready", z_in_ready, 1'b0);
    step();
    present(32'h00300193, 32'h1008);
    chk("fillC.in_ready", d_in_ready, 1'b0);
    chk("single.fillC.inst", z_out_inst, 32'h00100093);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall.in_ready", d_in_ready, 1'b0);
      chk("stall.valid", d_out_valid, 1'b1);
      chk("stall.inst", d_out_inst, 32'h00100093);
      chk("stall.pc", d_out_pc, 32'h1000);
      chk("stall.imm", d_out_imm, 32'h1);
    end
    out_ready = 1'b1;
    step();
    chk("drainB.inst", d_out_inst, 32'h00200113);
    chk("drainB.target", d_out_target, 32'h1006);
    chk("drainB.in_ready", d_in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    chk("drainC.inst", d_out_inst, 32'h00300193);
    chk("drainC.imm", d_out_imm, 32'h3);
    chk("drainC.valid", d_out_valid, 1'b1);
    step();
    chk("drained.valid", d_out_valid, 1'b0);

    // flush while full with a new entry offered
    out_ready = 1'b0;
    present(32'h00100093, 32'h2000);
    step();
    present(32'h00200113, 32'h2004);
    step();
    present(32'h00400213, 32'h2008);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush.out_valid", d_out_valid, 1'b0);
    chk("flush.in_ready", d_in_ready, 1'b1);
    chk("flush.single_valid", z_out_valid, 1'b0);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("flush.stays_empty", d_out_valid, 1'b0);
    end

    // reset mid-stream
    out_ready = 1'b0;
    present(32'h00100093, 32'h3000);
    step();
    present(32'h00200113, 32'h3004);
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    chk("midrst.out_valid", d_out_valid, 1'b0);
    chk("midrst.in_ready", d_in_ready, 1'b0);
    chk("midrst.inst", d_out_inst, 32'h0);
    chk("midrst.pc", d_out_pc, 32'h0);
    chk("midrst.imm", d_out_imm, 32'h0);
    chk("midrst.target", d_out_target, 32'h0);
    chk("midrst.type", d_out_type, 3'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    chk("midrst.after_ready", d_in_ready, 1'b1);
    chk("midrst.after_valid", d_out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
